// File: rtl/op_centric_queue_arbiter_if.sv
// Requester-side req/gnt/resp bundle plus the queue push_back/pop_front handshake.
// master = the arbiter; slave = the producers, consumers and queue around it.
interface op_centric_queue_arbiter_if #(
    parameter int p_num_reqs = 4,
    parameter int p_bitwidth = 32
);
    logic [p_num_reqs-1:0]            push_req;
    logic [p_num_reqs*p_bitwidth-1:0] push_data;
    logic [p_num_reqs-1:0]            push_gnt;
    logic [p_num_reqs-1:0]            pop_req;
    logic [p_num_reqs-1:0]            pop_gnt;
    logic [p_num_reqs-1:0]            pop_resp_val;
    logic [p_bitwidth-1:0]            pop_resp_data;
    logic                             q_push_back_en;
    logic                             q_push_back_rdy;
    logic [p_bitwidth-1:0]            q_push_back_data;
    logic                             q_pop_front_en;
    logic                             q_pop_front_rdy;
    logic [p_bitwidth-1:0]            q_pop_front_data;

    modport master (
        input  push_req, push_data, pop_req,
        input  q_push_back_rdy, q_pop_front_rdy, q_pop_front_data,
        output push_gnt, pop_gnt, pop_resp_val, pop_resp_data,
        output q_push_back_en, q_push_back_data, q_pop_front_en
    );

    modport slave (
        output push_req, push_data, pop_req,
        output q_push_back_rdy, q_pop_front_rdy, q_pop_front_data,
        input  push_gnt, pop_gnt, pop_resp_val, pop_resp_data,
        input  q_push_back_en, q_push_back_data, q_pop_front_en
    );
endinterface

// File: rtl/op_centric_queue_arbiter.sv
// Round-robin push/pop arbiter for one queue: push grant 1 cycle after the deciding edge,
// pop grant +1 / response +3; a path makes no grant while the queue's matching rdy is low.
module op_centric_queue_arbiter #(
    parameter int p_num_reqs = 4,
    parameter int p_bitwidth = 32
) (
    input  logic clk,
    input  logic rst,
    op_centric_queue_arbiter_if.master bus
);
    localparam int PW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
    typedef logic [PW-1:0] idx_t;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_PUSH = 1'b1
    } push_state_t;

    typedef enum logic [1:0] {
        OS_IDLE = 2'd0,
        OS_POP  = 2'd1,
        OS_CAPT = 2'd2,
        OS_RESP = 2'd3
    } pop_state_t;

    // First asserted request at or after ptr, wrapping.
    function automatic idx_t rr_pick(input logic [p_num_reqs-1:0] req, input idx_t ptr);
        idx_t win;
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        for (int off = 0; off < p_num_reqs; off++) begin
            idx = int'(ptr) + off;
            if (idx >= p_num_reqs) idx = idx - p_num_reqs;
            if (!found && req[idx]) begin
                win   = idx_t'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic idx_t rr_next(input idx_t win);
        return (int'(win) == p_num_reqs - 1) ? '0 : win + idx_t'(1);
    endfunction

    // ---------------- push path ----------------
    push_state_t push_state, push_state_nxt;
    idx_t        push_ptr, push_win, push_pick;
    logic        push_take;

    always_comb begin
        push_pick      = rr_pick(bus.push_req, push_ptr);
        push_take      = 1'b0;
        push_state_nxt = push_state;
        case (push_state)
            PS_IDLE: begin
                if (|bus.push_req && bus.q_push_back_rdy) begin
                    push_take      = 1'b1;
                    push_state_nxt = PS_PUSH;
                end
            end
            PS_PUSH: push_state_nxt = PS_IDLE;
            default: push_state_nxt = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) push_state <= PS_IDLE;
        else      push_state <= push_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_ptr             <= '0;
            push_win             <= '0;
            bus.q_push_back_data <= '0;
        end else if (push_take) begin
            push_ptr             <= rr_next(push_pick);
            push_win             <= push_pick;
            bus.q_push_back_data <= bus.push_data[int'(push_pick)*p_bitwidth +: p_bitwidth];
        end
    end

    always_comb begin
        bus.push_gnt       = '0;
        bus.q_push_back_en = (push_state == PS_PUSH);
        if (push_state == PS_PUSH) bus.push_gnt[push_win] = 1'b1;
    end

    // ---------------- pop path ----------------
    pop_state_t pop_state, pop_state_nxt;
    idx_t       pop_ptr, pop_win, pop_pick;
    logic       pop_take;

    always_comb begin
        pop_pick      = rr_pick(bus.pop_req, pop_ptr);
        pop_take      = 1'b0;
        pop_state_nxt = pop_state;
        case (pop_state)
            OS_IDLE: begin
                if (|bus.pop_req && bus.q_pop_front_rdy) begin
                    pop_take      = 1'b1;
                    pop_state_nxt = OS_POP;
                end
            end
            OS_POP:  pop_state_nxt = OS_CAPT;
            OS_CAPT: pop_state_nxt = OS_RESP;
            OS_RESP: pop_state_nxt = OS_IDLE;
            default: pop_state_nxt = OS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pop_state <= OS_IDLE;
        else      pop_state <= pop_state_nxt;
    end

    // The queue presents popped data the cycle after it sees pop_front_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_ptr           <= '0;
            pop_win           <= '0;
            bus.pop_resp_data <= '0;
        end else begin
            if (pop_take) begin
                pop_ptr <= rr_next(pop_pick);
                pop_win <= pop_pick;
            end
            if (pop_state == OS_CAPT) bus.pop_resp_data <= bus.q_pop_front_data;
        end
    end

    always_comb begin
        bus.pop_gnt        = '0;
        bus.pop_resp_val   = '0;
        bus.q_pop_front_en = (pop_state == OS_POP);
        if (pop_state == OS_POP)  bus.pop_gnt[pop_win]      = 1'b1;
        if (pop_state == OS_RESP) bus.pop_resp_val[pop_win] = 1'b1;
    end
endmodule

// File: tb/tb_op_centric_queue_arbiter.sv
// Bench: directed phases plus random traffic against a depth-8 queue model,
// scored by a transaction-level round-robin / FIFO-order reference.
module tb_op_centric_queue_arbiter;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    op_centric_queue_arbiter_if #(.p_num_reqs(N), .p_bitwidth(W)) bus ();
    op_centric_queue_arbiter #(.p_num_reqs(N), .p_bitwidth(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // queue environment
    logic [W-1:0] env_q[$];
    logic         env_push, env_pop;
    logic [W-1:0] env_push_val;

    // reference model: age = cycles since that path's last grant decision
    int           p_age, o_age, p_ptr, o_ptr, p_win, o_win;
    logic [W-1:0] m_qdata, m_rdata, o_data;
    logic [W-1:0] ref_q[$];

    // stimulus configuration
    logic [N-1:0] push_mask, pop_mask;
    int           push_prob, pop_prob, wd_prob, stall_prob;
    int           push_credits, pop_credits;
    logic [W-1:0] push_list[$];
    int           rst_cycles;
    int           cyc = 0;

    // observation logs
    int           pg_log[$], pg_cyc[$], og_log[$], og_cyc[$], rv_log[$], rv_cyc[$];
    logic [W-1:0] env_log[$], rv_data[$];

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int o = 0; o < N; o++)
            if (req[(ptr + o) % N]) return (ptr + o) % N;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_logs();
        pg_log.delete(); pg_cyc.delete(); og_log.delete(); og_cyc.delete();
        rv_log.delete(); rv_cyc.delete(); env_log.delete(); rv_data.delete();
    endtask

    task automatic model_reset();
        p_age = 99; o_age = 99; p_ptr = 0; o_ptr = 0; p_win = 0; o_win = 0;
        m_qdata = '0; m_rdata = '0; o_data = '0;
        ref_q.delete(); env_q.delete();
        env_push = 1'b0; env_pop = 1'b0;
    endtask

    task automatic cycle();
        logic [N-1:0] e_pg, e_og, e_rv;
        @(posedge clk);
        #1;
        cyc++;
        if (env_push) env_q.push_back(env_push_val);
        if (env_pop && env_q.size() > 0) bus.q_pop_front_data = env_q.pop_front();
        else                             bus.q_pop_front_data = $urandom;
        if (rst_cycles > 0) begin
            rst = 1'b0;
            rst_cycles--;
        end else begin
            rst = 1'b1;
        end
        bus.q_push_back_rdy = (env_q.size() < DEPTH) && ($urandom_range(99) >= stall_prob);
        bus.q_pop_front_rdy = (env_q.size() > 0)     && ($urandom_range(99) >= stall_prob);

        @(negedge clk);
        if (!rst) model_reset();
        if (o_age == 3) m_rdata = o_data;
        e_pg = (p_age == 1) ? onehot(p_win) : '0;
        e_og = (o_age == 1) ? onehot(o_win) : '0;
        e_rv = (o_age == 3) ? onehot(o_win) : '0;
        chk("push_gnt",         bus.push_gnt,         e_pg);
        chk("q_push_back_en",   bus.q_push_back_en,   p_age == 1);
        chk("q_push_back_data", bus.q_push_back_data, m_qdata);
        chk("pop_gnt",          bus.pop_gnt,          e_og);
        chk("q_pop_front_en",   bus.q_pop_front_en,   o_age == 1);
        chk("pop_resp_val",     bus.pop_resp_val,     e_rv);
        chk("pop_resp_data",    bus.pop_resp_data,    m_rdata);

        if (|bus.push_gnt) begin pg_log.push_back(oh_idx(bus.push_gnt)); pg_cyc.push_back(cyc); end
        if (bus.q_push_back_en) env_log.push_back(bus.q_push_back_data);
        if (|bus.pop_gnt) begin og_log.push_back(oh_idx(bus.pop_gnt)); og_cyc.push_back(cyc); end
        if (|bus.pop_resp_val) begin
            rv_log.push_back(oh_idx(bus.pop_resp_val));
            rv_cyc.push_back(cyc);
            rv_data.push_back(bus.pop_resp_data);
        end
        env_push     = bus.q_push_back_en;
        env_push_val = bus.q_push_back_data;
        env_pop      = bus.q_pop_front_en;

        for (int i = 0; i < N; i++) begin
            if (p_age == 1 && p_win == i) bus.push_req[i] = 1'b0;
            if (!push_mask[i]) bus.push_req[i] = 1'b0;
            else if (bus.push_req[i] && $urandom_range(99) < wd_prob) bus.push_req[i] = 1'b0;
            else if (!bus.push_req[i] && push_credits != 0 && $urandom_range(99) < push_prob) begin
                bus.push_req[i] = 1'b1;
                bus.push_data[i*W +: W] = (push_list.size() > 0) ? push_list.pop_front() : $urandom;
                if (push_credits > 0) push_credits--;
            end
            if (o_age == 1 && o_win == i) bus.pop_req[i] = 1'b0;
            if (!pop_mask[i]) bus.pop_req[i] = 1'b0;
            else if (bus.pop_req[i] && $urandom_range(99) < wd_prob) bus.pop_req[i] = 1'b0;
            else if (!bus.pop_req[i] && pop_credits != 0 && $urandom_range(99) < pop_prob) begin
                bus.pop_req[i] = 1'b1;
                if (pop_credits > 0) pop_credits--;
            end
        end

        if (rst) begin
            if (o_age >= 4 && |bus.pop_req && bus.q_pop_front_rdy) begin
                o_win  = rr_pick(bus.pop_req, o_ptr);
                o_data = (ref_q.size() > 0) ? ref_q.pop_front() : '0;
                o_ptr  = (o_win + 1) % N;
                o_age  = 1;
            end else if (o_age < 99) o_age++;
            if (p_age >= 2 && |bus.push_req && bus.q_push_back_rdy) begin
                p_win   = rr_pick(bus.push_req, p_ptr);
                m_qdata = bus.push_data[p_win*W +: W];
                ref_q.push_back(m_qdata);
                p_ptr   = (p_win + 1) % N;
                p_age   = 1;
            end else if (p_age < 99) p_age++;
        end
    endtask

    initial begin
        int found;
        bus.push_req = '0; bus.push_data = '0; bus.pop_req = '0;
        bus.q_push_back_rdy = 1'b0; bus.q_pop_front_rdy = 1'b0; bus.q_pop_front_data = '0;
        model_reset();
        rst_cycles = 6;
        push_mask = '1; pop_mask = '1; push_prob = 100; pop_prob = 100;
        wd_prob = 0; stall_prob = 0; push_credits = -1; pop_credits = -1;
        push_list = '{32'h11, 32'h22, 32'h33, 32'h44};

        // reset held with every request up, then four persistent producers
        repeat (6) cycle();
        pop_mask = '0;
        clear_logs();
        repeat (24) cycle();
        chk("first_push_gnt_idx", (pg_log.size() > 0) ? pg_log[0] : -1, 0);
        chk("fill_grant_count", pg_log.size(), DEPTH);
        for (int i = 0; i < pg_log.size() && i < DEPTH; i++) chk("rr_order", pg_log[i], i % N);
        for (int i = 0; i < env_log.size() && i < N; i++) chk("queue_data", env_log[i], 32'h11 * (i + 1));
        for (int i = 1; i < pg_cyc.size(); i++) chk("push_spacing", pg_cyc[i] - pg_cyc[i-1], 2);

        // fill from producer 2, 9th waits for a pop
        rst_cycles = 2; push_mask = 4'b0100;
        repeat (2) cycle();
        clear_logs();
        repeat (30) cycle();
        chk("p2_fill_count", pg_log.size(), DEPTH);
        for (int i = 0; i < pg_log.size(); i++) chk("p2_only", pg_log[i], 2);
        pop_mask = 4'b0001; pop_credits = 1;
        repeat (12) cycle();
        chk("p2_after_pop", pg_log.size(), DEPTH + 1);
        chk("p2_pop_count", og_log.size(), 1);

        // two consumers, FIFO data return
        rst_cycles = 2; push_mask = 4'b0001; push_credits = 2; pop_mask = '0;
        push_list = '{32'hA5, 32'h5A};
        repeat (2) cycle();
        clear_logs();
        repeat (8) cycle();
        pop_mask = 4'b1010; pop_credits = 2;
        repeat (14) cycle();
        chk("pair_gnt_count", og_log.size(), 2);
        chk("pair_resp_count", rv_log.size(), 2);
        if (og_log.size() == 2 && rv_log.size() == 2) begin
            chk("pair_gnt0", og_log[0], 1);
            chk("pair_gnt1", og_log[1], 3);
            chk("pair_resp0_idx", rv_log[0], 1);
            chk("pair_resp0_data", rv_data[0], 32'hA5);
            chk("pair_resp1_idx", rv_log[1], 3);
            chk("pair_resp1_data", rv_data[1], 32'h5A);
            chk("pair_lat0", rv_cyc[0] - og_cyc[0], 2);
            chk("pair_lat1", rv_cyc[1] - og_cyc[1], 2);
        end

        // empty queue: no pop grants, pointer stays at 0
        rst_cycles = 2; push_mask = '0; pop_mask = '1; pop_credits = -1;
        repeat (2) cycle();
        clear_logs();
        repeat (50) cycle();
        chk("empty_no_pop", og_log.size(), 0);
        push_mask = 4'b0010; push_credits = 1;
        repeat (10) cycle();
        chk("empty_then_first_pop", (og_log.size() > 0) ? og_log[0] : -1, 0);

        // reset during POP/CAPT drops the response
        push_credits = 1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            cycle();
            if (rst && o_age == 1) found = 1;
        end
        chk("midpop_reached", found, 1);
        clear_logs();
        rst_cycles = 2;
        repeat (2) cycle();
        push_credits = 1;
        repeat (20) cycle();
        chk("midpop_gnt_after", og_log.size(), 1);
        chk("midpop_resp_after", rv_log.size(), 1);
        if (og_log.size() == 1 && rv_log.size() == 1) chk("midpop_lat", rv_cyc[0] - og_cyc[0], 2);

        // random traffic with withdrawals and rdy stalls
        push_mask = '1; pop_mask = '1; push_prob = 40; pop_prob = 40;
        push_credits = -1; pop_credits = -1; wd_prob = 5; stall_prob = 15;
        repeat (3000) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/op_centric_queue_arbiter.md
# op_centric_queue_arbiter

Round-robin controller that shares one OpCentricQueue between `p_num_reqs` producers and `p_num_reqs` consumers. It sits between the requesters and the queue's push_back/pop_front ports. It serializes pushes and pops onto the queue's single-pulse enable handshakes, and it returns popped data to the consumer that won the grant. The push and pop paths are independent state machines that share only clock and reset.

## Interface
- p_num_reqs, 4, number of producers and number of consumers (≥2)
- p_bitwidth, 32, data width; must match the attached queue
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- push_req  in  p_num_reqs  producer i requests a push; held with data until its grant
- push_data  in  p_num_reqs*p_bitwidth  producer i data at bits [i*p_bitwidth +: p_bitwidth]
- push_gnt  out  p_num_reqs  one-hot, one-cycle pulse: producer i's data accepted
- pop_req  in  p_num_reqs  consumer i requests one element
- pop_gnt  out  p_num_reqs  one-hot, one-cycle pulse: consumer i's pop issued
- pop_resp_val  out  p_num_reqs  one-hot, one-cycle pulse: pop_resp_data belongs to consumer i
- pop_resp_data  out  p_bitwidth  popped element; holds its value until the next capture
- q_push_back_en  out  1  to queue push_back_en
- q_push_back_rdy  in  1  from queue push_back_rdy
- q_push_back_data  out  p_bitwidth  to queue push_back_data
- q_pop_front_en  out  1  to queue pop_front_en
- q_pop_front_rdy  in  1  from queue pop_front_rdy
- q_pop_front_data  in  p_bitwidth  from queue pop_front_data

## Operation
- Reset (rst=0, asynchronous) forces:
  - every output to 0;
  - both FSMs to IDLE;
  - both round-robin pointers to 0.
- Reset mid-transfer drops that transfer; no grant or response is emitted for it.
- Round-robin selection, common to both paths:
  - The winner is the first asserted req index at or after the pointer, wrapping modulo p_num_reqs.
  - On each grant, pointer <= (winner+1) mod p_num_reqs.
  - The pointer does not change when there is no grant.
- Push FSM, IDLE / PUSH:
  - IDLE: if any push_req and q_push_back_rdy are both 1, register the winner's data into q_push_back_data and go to PUSH.
  - PUSH: q_push_back_en=1 and push_gnt[winner]=1 for exactly this cycle, then IDLE.
  - q_push_back_data holds the last pushed value afterwards.
- Pop FSM, IDLE / POP / CAPT / RESP:
  - IDLE: if any pop_req and q_pop_front_rdy are both 1, latch the winner and go to POP.
  - POP: q_pop_front_en=1 and pop_gnt[winner]=1 for this cycle only.
  - CAPT: q_pop_front_en=0; at the end of this cycle, pop_resp_data <= q_pop_front_data.
  - RESP: pop_resp_val[winner]=1 for this cycle, then IDLE.
- Requests are sampled only in IDLE:
  - Deasserting a req after its grant has no effect.
  - Deasserting a req before its grant withdraws it silently.
- Full/empty:
  - With q_push_back_rdy=0 there are no push grants. Producers wait indefinitely and the pointer holds.
  - With q_pop_front_rdy=0 there are no pop grants.
- Push and pop may be in flight in the same cycle; the two paths never stall each other.
- Grant outputs are registered (FSM-state decoded). There is no combinational path from any input to any output.

## Timing
- Push: a request seen in IDLE at edge k gives q_push_back_en=1 and push_gnt=1 in cycle k+1. Earliest next push grant is cycle k+3.
  - One mandatory IDLE cycle lets the queue's rdy settle.
  - Maximum throughput is one push per 2 cycles.
- Pop: a request seen at edge k gives:
  - q_pop_front_en=1 and pop_gnt in cycle k+1;
  - data captured at the end of cycle k+2;
  - pop_resp_val in cycle k+3.
- Pop maximum throughput is one pop per 4 cycles.
- The queue must present pop data in the cycle after the cycle in which it samples pop_front_en (CAPT). The captured value is exactly that data.
- push_gnt, pop_gnt and pop_resp_val are never asserted for more than one consecutive cycle for the same transfer.

## Test plan
- Reset, then hold rst=0 across 5 clock edges with all reqs=1 -> all outputs 0 throughout. After release, the first push_gnt is 4'b0001.
- Four producers all requesting, data 0x11/0x22/0x33/0x44, queue depth 8 -> push_gnt order 0,1,2,3,0,… Queue receives 0x11,0x22,0x33,0x44. q_push_back_en pulses are spaced exactly 2 cycles apart.
- Fill the queue (depth 8) from producer 2 only -> exactly 8 push_gnt[2] pulses. A 9th request stays pending with q_push_back_en=0 until one pop completes, then it is granted.
- Push 0xA5, 0x5A. Consumers 1 and 3 request simultaneously -> pop_gnt[1] then pop_gnt[3]. Responses: pop_resp_val[1] with 0xA5, then pop_resp_val[3] with 0x5A, each 2 cycles after its pop_gnt.
- Empty queue with pop_req=4'b1111 -> no pop_gnt for 50 cycles. Pointer unchanged: after one push, the grant goes to consumer 0.
- Assert rst=0 during the POP/CAPT cycles of a pop -> no pop_resp_val afterwards. The FSM is in IDLE on release and the next pop is granted normally.
